// File: rtl/dev_bridge_n_pkg.sv
// dev_bridge_n_pkg: controller word offsets and shared limits for the device bridge
package dev_bridge_n_pkg;
   localparam logic [1:0] PEND = 2'd0;
   localparam logic [1:0] MASK = 2'd1;
   localparam logic [1:0] RAW = 2'd2;
   localparam logic [1:0] ERR = 2'd3;
   localparam logic [29:0] BASE_W_DEF = 30'h1FC0;
   localparam int NDEV_MAX = 6;
endpackage

// File: rtl/dev_bridge_n_irq_ctrl.sv
// irq_ctrl_n: per-channel edge/level interrupt capture with pending, mask and registered hw_int
module irq_ctrl_n #(
   parameter int NDEV = 3,
   parameter logic [5:0] IRQ_EDGE = 6'b000100
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NDEV-1:0] dev_irq,
   input  logic            wr_pend,
   input  logic            wr_mask,
   input  logic [NDEV-1:0] wd,
   output logic [NDEV-1:0] pending,
   output logic [NDEV-1:0] mask,
   output logic [5:0]      hw_int
);
   logic [NDEV-1:0] irq_d, irq_q, pend_d, pend_q, mask_d, mask_q;
   logic [5:0] hw_int_d, hw_int_q;
   always_comb begin
      irq_d = dev_irq;
      mask_d = wr_mask ? wd : mask_q;
      pend_d = '0;
      // edge channels: a fresh rising edge beats a simultaneous write-1-clear
      for (int i = 0; i < NDEV; i++)
         pend_d[i] = IRQ_EDGE[i] ? ((pend_q[i] && !(wr_pend && wd[i])) || (dev_irq[i] && !irq_q[i])) : dev_irq[i];
      hw_int_d = 6'(pend_q & mask_q);
   end
   always_ff @(posedge clk) begin
      irq_q <= reset ? '0 : irq_d;
      pend_q <= reset ? '0 : pend_d;
      mask_q <= reset ? '0 : mask_d;
      hw_int_q <= reset ? '0 : hw_int_d;
   end
   assign pending = pend_q;
   assign mask = mask_q;
   assign hw_int = hw_int_q;
endmodule

// File: rtl/dev_bridge_n.sv
// dev_bridge_n: CPU-to-device bridge with interrupt controller; DEVBRIDGE_ERRCNT_EN adds a miss-write counter at controller word 3
module dev_bridge_n
   import dev_bridge_n_pkg::*;
#(
   parameter int NDEV = 3,
   parameter logic [29:0] BASE_W = BASE_W_DEF,
   parameter int SLOT_AW = 2,
   parameter logic [5:0] IRQ_EDGE = 6'b000100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [29:0]        pr_addr,
   input  logic [31:0]        pr_wd,
   input  logic               we_cpu,
   input  logic [NDEV*32-1:0] dev_rd,
   input  logic [NDEV-1:0]    dev_irq,
   output logic [SLOT_AW-1:0] dev_addr,
   output logic [31:0]        dev_wd,
   output logic [NDEV-1:0]    dev_we,
   output logic               hit_dev,
   output logic [31:0]        pr_rd,
   output logic [5:0]         hw_int
);
   localparam logic [29:0] WIN = 30'((NDEV + 1) << SLOT_AW);
   if (NDEV < 1 || NDEV > NDEV_MAX) begin : g_bad_ndev
      $error("dev_bridge_n: NDEV must be in 1..6");
   end
   logic [29:0] off;
   logic [2:0] slot;
   logic ctrl_sel, ctrl_we;
   logic [31:0] ctrl_rd, dev_sel, err_rd, pr_rd_d, pr_rd_q;
   logic [NDEV-1:0] pending, mask;
   always_comb begin
      off = pr_addr - BASE_W;
      hit_dev = (pr_addr >= BASE_W) && (off < WIN);
      slot = 3'(off >> SLOT_AW);
      dev_addr = pr_addr[SLOT_AW-1:0];
      dev_wd = pr_wd;
      ctrl_sel = hit_dev && (slot == 3'(NDEV));
      ctrl_we = we_cpu && ctrl_sel && !reset;
      dev_we = '0;
      dev_sel = '0;
      for (int i = 0; i < NDEV; i++) begin
         dev_we[i] = we_cpu && hit_dev && !reset && (slot == 3'(i));
         dev_sel = (slot == 3'(i)) ? dev_rd[32*i +: 32] : dev_sel;
      end
      ctrl_rd = (dev_addr == SLOT_AW'(PEND)) ? 32'(pending) :
                (dev_addr == SLOT_AW'(MASK)) ? 32'(mask) :
                (dev_addr == SLOT_AW'(RAW))  ? 32'(dev_irq) :
                (dev_addr == SLOT_AW'(ERR))  ? err_rd : 32'b0;
      pr_rd_d = !hit_dev ? 32'b0 : ctrl_sel ? ctrl_rd : dev_sel;
   end
   always_ff @(posedge clk) begin
      pr_rd_q <= reset ? '0 : pr_rd_d;
   end
   assign pr_rd = pr_rd_q;
`ifdef DEVBRIDGE_ERRCNT_EN
   logic [7:0] err_d, err_q;
   always_comb begin
      err_d = (ctrl_we && dev_addr == SLOT_AW'(ERR)) ? 8'd0 :
              (we_cpu && !hit_dev && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   end
   always_ff @(posedge clk) begin
      err_q <= reset ? 8'd0 : err_d;
   end
   assign err_rd = {24'b0, err_q};
`else
   assign err_rd = 32'b0;
`endif
   irq_ctrl_n #(.NDEV(NDEV), .IRQ_EDGE(IRQ_EDGE)) u_irq (
      .clk     (clk),
      .reset   (reset),
      .dev_irq (dev_irq),
      .wr_pend (ctrl_we && dev_addr == SLOT_AW'(PEND)),
      .wr_mask (ctrl_we && dev_addr == SLOT_AW'(MASK)),
      .wd      (pr_wd[NDEV-1:0]),
      .pending (pending),
      .mask    (mask),
      .hw_int  (hw_int)
   );
endmodule
